// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolution unit: issue register (A) feeds the evaluator,
// output register (B) holds the resolved result until the writeback arbiter takes it.
module branch_resolve_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ROB_WIDTH  = 4,
   parameter int unsigned PREG_WIDTH = 7,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [DATA_WIDTH-1:0] i_op1,
   input  logic [DATA_WIDTH-1:0] i_op2,
   input  logic [DATA_WIDTH-1:0] i_pc,
   input  logic [DATA_WIDTH-1:0] i_imm,
   input  logic [3:0]            i_alu_op,
   input  logic [ROB_WIDTH-1:0]  i_rob_tag,
   input  logic [PREG_WIDTH-1:0] i_prd,
   input  logic                  i_pred_taken,
   input  logic [DATA_WIDTH-1:0] i_pred_target,
   input  logic                  i_flush,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [ROB_WIDTH-1:0]  o_rob_tag,
   output logic [PREG_WIDTH-1:0] o_prd,
   output logic [DATA_WIDTH-1:0] o_result,
   output logic                  o_taken,
   output logic [DATA_WIDTH-1:0] o_target_addr,
   output logic                  o_mispredict,
   output logic                  o_redirect_valid,
   output logic [DATA_WIDTH-1:0] o_redirect_pc,
   output logic [CNT_WIDTH-1:0]  o_branch_count,
   output logic [CNT_WIDTH-1:0]  o_mispredict_count
);

   logic                  a_valid;
   logic [DATA_WIDTH-1:0] a_op1, a_op2, a_pc, a_imm, a_pred_target;
   logic [3:0]            a_alu_op;
   logic [ROB_WIDTH-1:0]  a_rob_tag;
   logic [PREG_WIDTH-1:0] a_prd;
   logic                  a_pred_taken;

   logic                  advance_b, a_to_b, capture, handoff;
   logic [DATA_WIDTH-1:0] pc_plus4, br_target, jalr_sum, target, next_addr;
   logic                  taken, lt_s, lt_u, mispredict;

   assign advance_b = !o_valid || i_ready;
   assign a_to_b    = a_valid && advance_b;
   assign o_ready   = (!a_valid || advance_b) && !i_flush;
   assign capture   = i_valid && o_ready;
   assign handoff   = o_valid && i_ready && !i_flush;

   assign pc_plus4  = a_pc + DATA_WIDTH'(4);
   assign br_target = a_pc + a_imm;
   assign jalr_sum  = a_op1 + a_imm;
   assign lt_s      = $signed(a_op1) < $signed(a_op2);
   assign lt_u      = a_op1 < a_op2;

   always_comb begin
      taken  = 1'b0;
      target = br_target;
      if (a_alu_op == 4'b1000) begin
         taken = 1'b1;
      end else if (a_alu_op == 4'b1001) begin
         taken  = 1'b1;
         target = {jalr_sum[DATA_WIDTH-1:1], 1'b0};
      end else begin
         // Bit 3 is a don't-care for conditional branches; only funct3 decodes.
         case (a_alu_op[2:0])
            3'b000:  taken = (a_op1 == a_op2);
            3'b001:  taken = (a_op1 != a_op2);
            3'b100:  taken = lt_s;
            3'b101:  taken = !lt_s;
            3'b110:  taken = lt_u;
            3'b111:  taken = !lt_u;
            default: taken = 1'b0;
         endcase
      end
   end

   assign next_addr  = taken ? target : pc_plus4;
   assign mispredict = (taken != a_pred_taken) || (taken && (target != a_pred_target));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid       <= 1'b0;
         a_op1         <= '0;
         a_op2         <= '0;
         a_pc          <= '0;
         a_imm         <= '0;
         a_alu_op      <= '0;
         a_rob_tag     <= '0;
         a_prd         <= '0;
         a_pred_taken  <= 1'b0;
         a_pred_target <= '0;
      end else if (i_flush) begin
         a_valid <= 1'b0;
      end else if (capture) begin
         a_valid       <= 1'b1;
         a_op1         <= i_op1;
         a_op2         <= i_op2;
         a_pc          <= i_pc;
         a_imm         <= i_imm;
         a_alu_op      <= i_alu_op;
         a_rob_tag     <= i_rob_tag;
         a_prd         <= i_prd;
         a_pred_taken  <= i_pred_taken;
         a_pred_target <= i_pred_target;
      end else if (a_to_b) begin
         a_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid       <= 1'b0;
         o_rob_tag     <= '0;
         o_prd         <= '0;
         o_result      <= '0;
         o_taken       <= 1'b0;
         o_target_addr <= '0;
         o_mispredict  <= 1'b0;
      end else if (i_flush) begin
         o_valid <= 1'b0;
      end else if (a_to_b) begin
         o_valid       <= 1'b1;
         o_rob_tag     <= a_rob_tag;
         o_prd         <= a_prd;
         o_result      <= pc_plus4;
         o_taken       <= taken;
         o_target_addr <= next_addr;
         o_mispredict  <= mispredict;
      end else if (handoff) begin
         o_valid <= 1'b0;
      end
   end

   // Redirect is registered off the handoff itself, so a flush arriving the
   // following cycle cannot cancel a pulse that has already been launched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_redirect_valid   <= 1'b0;
         o_redirect_pc      <= '0;
         o_branch_count     <= '0;
         o_mispredict_count <= '0;
      end else begin
         o_redirect_valid <= handoff && o_mispredict;
         if (handoff && o_mispredict) begin
            o_redirect_pc <= o_target_addr;
         end
         if (handoff && (o_branch_count != '1)) begin
            o_branch_count <= o_branch_count + 1'b1;
         end
         if (handoff && o_mispredict && (o_mispredict_count != '1)) begin
            o_mispredict_count <= o_mispredict_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus randomized traffic
// scored against a queue-based model of a two-entry, one-cycle-minimum pipeline.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_valid = 1'b0, i_ready = 1'b1, i_flush = 1'b0, i_pred_taken = 1'b0;
   logic [31:0] i_op1 = '0, i_op2 = '0, i_pc = '0, i_imm = '0, i_pred_target = '0;
   logic [3:0]  i_alu_op = '0, i_rob_tag = '0;
   logic [6:0]  i_prd = '0;

   logic        o_ready, o_valid, o_taken, o_mispredict, o_redirect_valid;
   logic [3:0]  o_rob_tag;
   logic [6:0]  o_prd;
   logic [31:0] o_result, o_target_addr, o_redirect_pc;
   logic [15:0] o_branch_count, o_mispredict_count;

   logic        d2_ready, d2_valid, d2_taken, d2_mispredict, d2_redirect_valid;
   logic [3:0]  d2_rob_tag;
   logic [6:0]  d2_prd;
   logic [31:0] d2_result, d2_target_addr, d2_redirect_pc;
   logic [1:0]  d2_branch_count, d2_mispredict_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   branch_resolve_unit dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_op1(i_op1), .i_op2(i_op2), .i_pc(i_pc), .i_imm(i_imm), .i_alu_op(i_alu_op),
      .i_rob_tag(i_rob_tag), .i_prd(i_prd), .i_pred_taken(i_pred_taken),
      .i_pred_target(i_pred_target), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
      .o_rob_tag(o_rob_tag), .o_prd(o_prd), .o_result(o_result), .o_taken(o_taken),
      .o_target_addr(o_target_addr), .o_mispredict(o_mispredict),
      .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
      .o_branch_count(o_branch_count), .o_mispredict_count(o_mispredict_count)
   );

   // Narrow-counter copy sharing every input, used to observe saturation.
   branch_resolve_unit #(.CNT_WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(d2_ready),
      .i_op1(i_op1), .i_op2(i_op2), .i_pc(i_pc), .i_imm(i_imm), .i_alu_op(i_alu_op),
      .i_rob_tag(i_rob_tag), .i_prd(i_prd), .i_pred_taken(i_pred_taken),
      .i_pred_target(i_pred_target), .i_flush(i_flush), .o_valid(d2_valid), .i_ready(i_ready),
      .o_rob_tag(d2_rob_tag), .o_prd(d2_prd), .o_result(d2_result), .o_taken(d2_taken),
      .o_target_addr(d2_target_addr), .o_mispredict(d2_mispredict),
      .o_redirect_valid(d2_redirect_valid), .o_redirect_pc(d2_redirect_pc),
      .o_branch_count(d2_branch_count), .o_mispredict_count(d2_mispredict_count)
   );

   typedef struct {
      logic [31:0] result;
      logic [31:0] addr;
      logic [31:0] tgt;
      logic        taken;
      logic        mis;
      logic [3:0]  tag;
      logic [6:0]  prd;
      int          vis;
   } exp_t;

   exp_t        m_q[$];
   exp_t        m_nb, m_tmp, mon_h;
   int          ecount = 0, m_e = 0, bc = 0, mc = 0;
   logic        m_red = 1'b0, m_hand, m_cap, mon_v, mon_r;
   logic [31:0] m_red_pc = '0;

   function automatic exp_t ref_eval();
      exp_t        r;
      logic [31:0] sum;
      r.result = i_pc + 32'd4;
      r.tgt    = i_pc + i_imm;
      r.taken  = 1'b0;
      if (i_alu_op == 4'd8) begin
         r.taken = 1'b1;
      end else if (i_alu_op == 4'd9) begin
         r.taken = 1'b1;
         sum     = i_op1 + i_imm;
         r.tgt   = sum & ~32'd1;
      end else begin
         case (i_alu_op[2:0])
            3'd0: r.taken = (i_op1 == i_op2);
            3'd1: r.taken = (i_op1 != i_op2);
            3'd4: r.taken = ($signed(i_op1) < $signed(i_op2));
            3'd5: r.taken = ($signed(i_op1) >= $signed(i_op2));
            3'd6: r.taken = (i_op1 < i_op2);
            3'd7: r.taken = (i_op1 >= i_op2);
            default: r.taken = 1'b0;
         endcase
      end
      r.addr = r.taken ? r.tgt : r.result;
      r.mis  = (r.taken != i_pred_taken) || (r.taken && (r.tgt != i_pred_target));
      r.tag  = i_rob_tag;
      r.prd  = i_prd;
      r.vis  = 0;
      return r;
   endfunction

   // Model: FIFO of at most two beats; a beat becomes visible one edge after
   // capture, or on the edge its predecessor leaves, whichever is later.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         bc = 0;
         mc = 0;
         m_red = 1'b0;
         m_red_pc = '0;
      end else begin
         m_e    = ecount + 1;
         m_hand = (m_q.size() > 0) && (m_q[0].vis <= ecount) && i_ready && !i_flush;
         m_cap  = i_valid && !i_flush && ((m_q.size() < 2) || i_ready);
         m_nb   = ref_eval();
         m_nb.vis = m_e + 1;
         m_red  = 1'b0;
         if (i_flush) begin
            m_q.delete();
         end else begin
            if (m_hand) begin
               bc++;
               if (m_q[0].mis) begin
                  mc++;
                  m_red    = 1'b1;
                  m_red_pc = m_q[0].addr;
               end
               void'(m_q.pop_front());
               if (m_q.size() > 0 && m_q[0].vis < m_e) begin
                  m_tmp = m_q[0];
                  m_tmp.vis = m_e;
                  m_q[0] = m_tmp;
               end
            end
            if (m_cap) m_q.push_back(m_nb);
         end
         ecount = m_e;
      end
   end

   function automatic int sat(int v, int mx);
      return (v > mx) ? mx : v;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         mon_v = (m_q.size() > 0) && (m_q[0].vis <= ecount);
         mon_r = !i_flush && ((m_q.size() < 2) || i_ready);
         n_tests += 5;
         if (o_valid !== mon_v) begin
            n_fail++;
            $display("FAIL mon_o_valid t=%0t got %b exp %b", $time, o_valid, mon_v);
         end
         if (o_ready !== mon_r) begin
            n_fail++;
            $display("FAIL mon_o_ready t=%0t got %b exp %b", $time, o_ready, mon_r);
         end
         if (o_redirect_valid !== m_red || (m_red && o_redirect_pc !== m_red_pc)) begin
            n_fail++;
            $display("FAIL mon_redirect t=%0t got %b/%h exp %b/%h", $time,
                     o_redirect_valid, o_redirect_pc, m_red, m_red_pc);
         end
         if (o_branch_count !== 16'(sat(bc, 65535)) || o_mispredict_count !== 16'(sat(mc, 65535))) begin
            n_fail++;
            $display("FAIL mon_counters t=%0t got %0d/%0d exp %0d/%0d", $time,
                     o_branch_count, o_mispredict_count, bc, mc);
         end
         if (d2_branch_count !== 2'(sat(bc, 3)) || d2_mispredict_count !== 2'(sat(mc, 3))) begin
            n_fail++;
            $display("FAIL mon_sat_counters t=%0t got %0d/%0d exp %0d/%0d", $time,
                     d2_branch_count, d2_mispredict_count, sat(bc, 3), sat(mc, 3));
         end
         if (mon_v) begin
            mon_h = m_q[0];
            n_tests++;
            if ({o_result, o_target_addr, o_taken, o_mispredict, o_rob_tag, o_prd} !==
                {mon_h.result, mon_h.addr, mon_h.taken, mon_h.mis, mon_h.tag, mon_h.prd}) begin
               n_fail++;
               $display("FAIL mon_fields t=%0t got res=%h addr=%h tk=%b mis=%b tag=%h prd=%h exp res=%h addr=%h tk=%b mis=%b tag=%h prd=%h",
                        $time, o_result, o_target_addr, o_taken, o_mispredict, o_rob_tag, o_prd,
                        mon_h.result, mon_h.addr, mon_h.taken, mon_h.mis, mon_h.tag, mon_h.prd);
            end
         end
      end
   end

   task automatic set_beat(input logic [3:0] op, input logic [31:0] op1, input logic [31:0] op2,
                           input logic [31:0] pc, input logic [31:0] imm, input logic pt,
                           input logic [31:0] ptgt, input logic [3:0] tag);
      i_alu_op = op; i_op1 = op1; i_op2 = op2; i_pc = pc; i_imm = imm;
      i_pred_taken = pt; i_pred_target = ptgt; i_rob_tag = tag; i_prd = {3'd0, tag};
   endtask

   task automatic drain();
      i_valid = 1'b0; i_ready = 1'b1; i_flush = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      n_tests++;
      if (o_valid !== 1'b0 || o_redirect_valid !== 1'b0 || o_branch_count !== 16'd0 ||
          o_mispredict_count !== 16'd0 || o_result !== 32'd0 || o_target_addr !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_state got v=%b rv=%b bc=%0d mc=%0d res=%h addr=%h exp all zero",
                  o_valid, o_redirect_valid, o_branch_count, o_mispredict_count, o_result, o_target_addr);
      end
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      n_tests++;
      if (o_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready got %b exp 1", o_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_beq();
      set_beat(4'b0000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 32'h120, 4'd1);
      i_valid = 1'b1; i_ready = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      n_tests++;
      if (o_valid !== 1'b0) begin
         n_fail++; $display("FAIL beq_latency got o_valid=%b exp 0", o_valid);
      end
      @(posedge clk); #1;
      n_tests++;
      if (o_valid !== 1'b1 || o_taken !== 1'b1 || o_target_addr !== 32'h120 ||
          o_mispredict !== 1'b0 || o_result !== 32'h104) begin
         n_fail++;
         $display("FAIL beq_result got v=%b tk=%b addr=%h mis=%b res=%h exp 1 1 120 0 104",
                  o_valid, o_taken, o_target_addr, o_mispredict, o_result);
      end
      @(posedge clk); #1;
      n_tests++;
      if (o_redirect_valid !== 1'b0 || o_branch_count !== 16'd1) begin
         n_fail++;
         $display("FAIL beq_count got rv=%b bc=%0d exp 0 1", o_redirect_valid, o_branch_count);
      end
      drain();
   endtask

   task automatic test_jalr();
      set_beat(4'b1001, 32'h1003, 32'h0, 32'h2000, 32'h4, 1'b1, 32'h1004, 4'd2);
      i_valid = 1'b1; i_ready = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (o_valid !== 1'b1 || o_taken !== 1'b1 || o_target_addr !== 32'h1006 ||
          o_mispredict !== 1'b1 || o_result !== 32'h2004 || o_redirect_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL jalr_result got v=%b tk=%b addr=%h mis=%b res=%h rv=%b exp 1 1 1006 1 2004 0",
                  o_valid, o_taken, o_target_addr, o_mispredict, o_result, o_redirect_valid);
      end
      @(posedge clk); #1;
      n_tests++;
      if (o_redirect_valid !== 1'b1 || o_redirect_pc !== 32'h1006 ||
          o_mispredict_count !== 16'd1 || o_branch_count !== 16'd2) begin
         n_fail++;
         $display("FAIL jalr_redirect got rv=%b pc=%h mc=%0d bc=%0d exp 1 1006 1 2",
                  o_redirect_valid, o_redirect_pc, o_mispredict_count, o_branch_count);
      end
      @(posedge clk); #1;
      n_tests++;
      if (o_redirect_valid !== 1'b0) begin
         n_fail++; $display("FAIL jalr_pulse_width got rv=%b exp 0", o_redirect_valid);
      end
      drain();
   endtask

   task automatic test_signed_wrap();
      i_ready = 1'b1; i_valid = 1'b1;
      set_beat(4'b0100, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b1, 32'h340, 4'd3);
      @(posedge clk); #1;
      set_beat(4'b0110, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b0, 32'h340, 4'd4);
      @(posedge clk); #1;
      n_tests++;
      if (o_taken !== 1'b1 || o_target_addr !== 32'h340 || o_mispredict !== 1'b0) begin
         n_fail++;
         $display("FAIL blt_signed got tk=%b addr=%h mis=%b exp 1 340 0", o_taken, o_target_addr, o_mispredict);
      end
      set_beat(4'b1000, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h8, 1'b1, 32'h4, 4'd5);
      @(posedge clk); #1;
      i_valid = 1'b0;
      n_tests++;
      if (o_taken !== 1'b0 || o_target_addr !== 32'h304 || o_mispredict !== 1'b0) begin
         n_fail++;
         $display("FAIL bltu_unsigned got tk=%b addr=%h mis=%b exp 0 304 0", o_taken, o_target_addr, o_mispredict);
      end
      @(posedge clk); #1;
      n_tests++;
      if (o_taken !== 1'b1 || o_target_addr !== 32'h4 || o_result !== 32'h0 || o_mispredict !== 1'b0) begin
         n_fail++;
         $display("FAIL jal_wrap got tk=%b addr=%h res=%h mis=%b exp 1 4 0 0",
                  o_taken, o_target_addr, o_result, o_mispredict);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [3:0] got[$];
      int k = 0;
      i_ready = 1'b0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         i_ready = (cyc >= 3);
         i_valid = (k < 4);
         set_beat(4'b0000, 32'd7, 32'd7, 32'h400 + 32'(16 * k), 32'h8, 1'b1,
                  32'h408 + 32'(16 * k), 4'(k + 8));
         @(negedge clk);
         if (o_valid && i_ready) got.push_back(o_rob_tag);
         if (cyc == 2) begin
            n_tests++;
            if (o_ready !== 1'b0) begin
               n_fail++; $display("FAIL b2b_full_ready got %b exp 0", o_ready);
            end
         end
         if (i_valid && ((m_q.size() < 2) || i_ready)) k++;
         @(posedge clk); #1;
      end
      i_valid = 1'b0;
      n_tests++;
      if (got.size() != 4) begin
         n_fail++; $display("FAIL b2b_count got %0d exp 4", got.size());
      end else begin
         for (int j = 0; j < 4; j++) begin
            n_tests++;
            if (got[j] !== 4'(j + 8)) begin
               n_fail++; $display("FAIL b2b_order idx %0d got %h exp %h", j, got[j], 4'(j + 8));
            end
         end
      end
      drain();
   endtask

   task automatic test_flush();
      i_ready = 1'b0; i_valid = 1'b1;
      set_beat(4'b1000, 32'h0, 32'h0, 32'h500, 32'h10, 1'b0, 32'h0, 4'd6);
      @(posedge clk); #1;
      i_valid = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (o_valid !== 1'b1 || o_mispredict !== 1'b1) begin
         n_fail++; $display("FAIL flush_setup got v=%b mis=%b exp 1 1", o_valid, o_mispredict);
      end
      i_flush = 1'b1; i_valid = 1'b1;
      @(posedge clk); #1;
      i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      n_tests++;
      if (o_valid !== 1'b0 || o_redirect_valid !== 1'b0 || o_branch_count !== 16'd9 ||
          o_mispredict_count !== 16'd1) begin
         n_fail++;
         $display("FAIL flush_kill got v=%b rv=%b bc=%0d mc=%0d exp 0 0 9 1",
                  o_valid, o_redirect_valid, o_branch_count, o_mispredict_count);
      end
      @(posedge clk); #1;
      n_tests++;
      if (o_valid !== 1'b0 || o_redirect_valid !== 1'b0 || d2_branch_count !== 2'd3) begin
         n_fail++;
         $display("FAIL flush_after got v=%b rv=%b sat_bc=%0d exp 0 0 3",
                  o_valid, o_redirect_valid, d2_branch_count);
      end
      drain();
   endtask

   task automatic test_random();
      exp_t e;
      for (int c = 0; c < 800; c++) begin
         i_flush = ($urandom_range(39) == 0);
         i_ready = ($urandom_range(3) != 0);
         i_valid = ($urandom_range(3) != 0);
         i_alu_op = 4'($urandom);
         i_op2 = $urandom;
         case ($urandom_range(3))
            0: i_op1 = i_op2;
            1: i_op1 = 32'($urandom_range(8));
            default: i_op1 = $urandom;
         endcase
         if ($urandom_range(1) == 1) i_op2 = 32'($urandom_range(8));
         i_pc  = ($urandom_range(7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(3) * 4) : ($urandom & ~32'd3);
         i_imm = ($urandom_range(1) == 1) ? 32'($urandom_range(255)) : $urandom;
         i_rob_tag = 4'($urandom);
         i_prd = 7'($urandom);
         i_pred_taken = 1'($urandom);
         i_pred_target = $urandom;
         e = ref_eval();
         if ($urandom_range(1) == 1) begin
            i_pred_taken  = e.taken;
            i_pred_target = e.tgt;
         end
         if (c == 400) begin
            #1;
            rst_n = 1'b0;
            #1;
            n_tests++;
            if (o_valid !== 1'b0 || o_redirect_valid !== 1'b0 || o_branch_count !== 16'd0) begin
               n_fail++;
               $display("FAIL async_reset got v=%b rv=%b bc=%0d exp 0 0 0",
                        o_valid, o_redirect_valid, o_branch_count);
            end
         end
         if (c == 402) rst_n = 1'b1;
         @(posedge clk); #1;
      end
      drain();
      n_tests++;
      if (o_branch_count !== 16'(bc) || bc < 12) begin
         n_fail++; $display("FAIL random_total got %0d exp %0d (min 12)", o_branch_count, bc);
      end
   endtask

   initial begin
      test_reset();
      test_beq();
      test_jalr();
      test_signed_wrap();
      test_back_to_back();
      test_flush();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Two-stage pipelined, back-pressurable branch resolution unit with parameterised datapath, ROB-tag and physical-register widths. It generalises the single-cycle branch evaluator with a valid/ready handshake on both sides, a global flush, a registered redirect pulse, and saturating branch/mispredict statistics counters. It sits between the branch reservation station (issue side) and the CDB/ROB writeback arbiter (result side), and drives the fetch-redirect path.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/PC/target width
- ROB_WIDTH, 4, ROB tag width
- PREG_WIDTH, 7, physical destination register width
- CNT_WIDTH, 16, statistics counter width

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  issue beat valid
- o_ready  out  1  unit can accept an issue beat this cycle
- i_op1, i_op2, i_pc, i_imm  in  DATA_WIDTH each  operands, branch PC, immediate
- i_alu_op  in  4  4'b1000 JAL, 4'b1001 JALR, otherwise {1'bx, funct3} conditional branch
- i_rob_tag  in  ROB_WIDTH  ROB tag
- i_prd  in  PREG_WIDTH  link destination
- i_pred_taken  in  1  predicted direction
- i_pred_target  in  DATA_WIDTH  predicted target
- i_flush  in  1  pipeline flush; kills all in-flight beats
- o_valid  out  1  result beat valid
- i_ready  in  1  writeback arbiter accepts result beat
- o_rob_tag, o_prd  out  ROB_WIDTH, PREG_WIDTH  passthrough
- o_result  out  DATA_WIDTH  link address pc+4
- o_taken  out  1  actual outcome
- o_target_addr  out  DATA_WIDTH  correct next PC
- o_mispredict  out  1  mispredict flag of current result beat
- o_redirect_valid  out  1  one-cycle fetch redirect pulse
- o_redirect_pc  out  DATA_WIDTH  redirect PC, valid with pulse
- o_branch_count, o_mispredict_count  out  CNT_WIDTH each  statistics

## Operation
- Stage A (issue register): captures inputs when i_valid && o_ready && !i_flush.
- Evaluation (combinational from stage A): JAL/JALR taken; funct3 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU, 010/011 not taken.
- Target: JALR (op1+imm) with bit0 cleared; otherwise pc+imm. All sums modulo 2^DATA_WIDTH (wrap, no carry-out).
- o_target_addr = taken ? target : pc+4; o_result = pc+4.
- Mispredict = (taken != pred_taken) || (taken && target != pred_target). Not-taken with differing pred_target is not a mispredict.
- Stage B (output register): holds all o_* result fields; o_valid = stage B valid.
- advance_B = !B_valid || i_ready; A moves to B when A_valid && advance_B; o_ready = (!A_valid || advance_B) && !i_flush.
- Result fields stable while o_valid && !i_ready.
- On output handshake (o_valid && i_ready && !i_flush): o_branch_count += 1; if o_mispredict, o_mispredict_count += 1 and next cycle o_redirect_valid=1, o_redirect_pc=o_target_addr. Counters saturate at all-ones.
- i_flush: synchronously clears A_valid and B_valid; beat in B not handed off; no redirect, no counting; counters keep their value. A redirect pulse already registered still fires.

## Timing
- Reset: A_valid=B_valid=0, o_valid=0, o_redirect_valid=0, counters=0, all data outputs 0; o_ready=1 after reset deasserts.
- Latency: accepted at edge N -> o_valid high after edge N+1 (two-stage, one cycle in A).
- Throughput: one beat/cycle with i_ready held high.
- Redirect pulse: exactly one cycle, in the cycle after the mispredicting handoff.
- Full: A and B valid, i_ready=0 -> o_ready=0; the beat on i_* is not captured.
- Simultaneous B handoff and A->B move and new capture in one cycle is legal.
- Simultaneous flush and issue: issue dropped.
- Reset mid-operation: all in-flight beats and pending redirect lost immediately (asynchronous).

## Test plan
- BEQ op1=op2=5, pc=0x100, imm=0x20, pred_taken=1, pred_target=0x120 -> two cycles later o_valid, o_taken=1, o_target_addr=0x120, o_mispredict=0, no redirect, branch_count=1.
- JALR op1=0x1003, imm=0x4, pred_target=0x1004 -> target 0x1006, o_mispredict=1, o_result=pc+4; redirect pulse one cycle after handoff, o_redirect_pc=0x1006, mispredict_count=1.
- BLT op1=0xFFFFFFFF, op2=1 (taken) vs BLTU same operands (not taken, o_target_addr=pc+4); pc=0xFFFFFFFC JAL imm=8 -> target 0x4 (wrap).
- Back-to-back 4 beats with i_ready=0 for 3 cycles -> o_ready drops after 2 beats captured, o_valid fields stable, all 4 delivered in order once i_ready=1.
- Mispredicting beat in B with i_ready=0, assert i_flush -> o_valid=0 next cycle, no redirect, counters unchanged.
- CNT_WIDTH=2, 5 handoffs -> o_branch_count stays 3.
